// File: rtl/rgmii_rx.sv
// rgmii_rx: RGMII receiver for the 125 MHz board link.
// Deserialises DDR nibbles, validates preamble/SFD/destination MAC/ethertype/FCS,
// writes the fixed-size payload into the inactive bank of a ping-pong sample RAM,
// and commits bank index + sequence number only for frames passing every check.
// Optional feature macro: RX_STATS_EN (good/dropped frame counters).
module rgmii_rx #(
  parameter logic [47:0] MAC_ADDR    = 48'h0088_dab8_bf08,
  parameter logic [15:0] ETHERTYPE   = 16'h1919,
  parameter int unsigned PAYLOAD_LEN = 1024,
  parameter int unsigned AW          = 10
) (
  input  logic          clk125,
  input  logic          rst,
  input  logic          rxctl,
  input  logic [3:0]    rxd,
  output logic [AW:0]   rxad,
  output logic [7:0]    rxdata,
  output logic          rxwe,
  output logic          idx,
  output logic [15:0]   seq,
  output logic          frame_ok,
  output logic          frame_err,
  output logic [15:0]   good_cnt,
  output logic [15:0]   err_cnt
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_PAY,
    S_FCS,
    S_DROP
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] cnt, cnt_n;
  logic [31:0]   crc, crc_n;
  logic [15:0]   shadow, shadow_n;
  logic [3:0]    lo;
  logic [7:0]    rbyte;
  logic [7:0]    mac_byte;
  logic          wbank;
  logic          tail, tail_n;
  logic          ok_n, err_n, we_n, hdr_bad;

  // Reflected CRC-32 over one byte, LSB first
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic [7:0]  b;
    r = c;
    b = d;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[0] ^ b[0]) r = (r >> 1) ^ CRC_POLY;
      else             r = r >> 1;
      b = b >> 1;
    end
    return r;
  endfunction

  // Low nibble is presented while clk125 is high; capture it on the falling edge
  always_ff @(negedge clk125 or posedge rst) begin
    if (rst) lo <= '0;
    else     lo <= rxd;
  end

  assign rbyte    = {rxd, lo};
  assign mac_byte = 8'(MAC_ADDR >> {cnt[2:0], 3'b000});

  // State register
  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state, per-byte datapath updates and event pulses
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    crc_n    = crc;
    shadow_n = shadow;
    tail_n   = 1'b0;
    ok_n     = 1'b0;
    err_n    = 1'b0;
    we_n     = 1'b0;
    hdr_bad  = 1'b0;
    case (state)
      S_IDLE: begin
        crc_n = '1;
        if (rxctl) begin
          // tail: rxctl still high right after the last FCS byte, so the
          // trailing bytes are swallowed silently rather than parsed
          if (tail) state_n = S_DROP;
          else if (rbyte == 8'h55) begin
            state_n = S_PRE;
            cnt_n   = AW'(1);
          end
        end
      end
      S_PRE: begin
        if (!rxctl) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else if (rbyte == 8'h55 && cnt < AW'(7)) begin
          cnt_n = cnt + 1'b1;
        end else if (rbyte == 8'hD5) begin
          state_n = S_HDR;
          cnt_n   = '0;
          crc_n   = '1;
        end else begin
          err_n   = 1'b1;
          state_n = S_DROP;
        end
      end
      S_HDR: begin
        if (!rxctl) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          crc_n = crc_byte(crc, rbyte);
          cnt_n = cnt + 1'b1;
          if (cnt < AW'(6))        hdr_bad = (rbyte != mac_byte);
          else if (cnt == AW'(12)) hdr_bad = (rbyte != ETHERTYPE[15:8]);
          else if (cnt == AW'(13)) hdr_bad = (rbyte != ETHERTYPE[7:0]);
          else if (cnt == AW'(14)) shadow_n[7:0]  = rbyte;
          else if (cnt == AW'(15)) shadow_n[15:8] = rbyte;
          if (hdr_bad) begin
            err_n   = 1'b1;
            state_n = S_DROP;
          end else if (cnt == AW'(15)) begin
            state_n = S_PAY;
            cnt_n   = '0;
          end
        end
      end
      S_PAY: begin
        if (!rxctl) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          crc_n = crc_byte(crc, rbyte);
          we_n  = 1'b1;
          cnt_n = cnt + 1'b1;
          if (cnt == AW'(PAYLOAD_LEN - 1)) begin
            state_n = S_FCS;
            cnt_n   = '0;
          end
        end
      end
      S_FCS: begin
        if (!rxctl) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          crc_n = crc_byte(crc, rbyte);
          cnt_n = cnt + 1'b1;
          if (cnt == AW'(3)) begin
            state_n = S_IDLE;
            tail_n  = 1'b1;
            if (crc_n == CRC_RESIDUE) ok_n  = 1'b1;
            else                      err_n = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (!rxctl) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath registers, RAM write port and commit of bank/sequence
  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      crc       <= '1;
      shadow    <= '0;
      tail      <= 1'b0;
      wbank     <= 1'b1;
      idx       <= 1'b0;
      seq       <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      rxwe      <= 1'b0;
      rxad      <= '0;
      rxdata    <= '0;
    end else begin
      cnt       <= cnt_n;
      crc       <= crc_n;
      shadow    <= shadow_n;
      tail      <= tail_n;
      frame_ok  <= ok_n;
      frame_err <= err_n;
      rxwe      <= we_n;
      if (we_n) begin
        rxad   <= {wbank, cnt};
        rxdata <= rbyte;
      end
      if (ok_n) begin
        idx   <= wbank;
        wbank <= ~wbank;
        seq   <= shadow;
      end
    end
  end

`ifdef RX_STATS_EN
  // Saturating good/dropped frame counters
  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) begin
      good_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (frame_ok && good_cnt != '1) good_cnt <= good_cnt + 1'b1;
      if (frame_err && err_cnt != '1) err_cnt  <= err_cnt + 1'b1;
    end
  end
`else
  assign good_cnt = '0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_rgmii_rx.sv
// tb_rgmii_rx: directed + randomized frames against a frame-level reference model.
module tb_rgmii_rx;

  localparam int          PL  = 1024;
  localparam logic [47:0] MAC = 48'h0088_dab8_bf08;
  localparam logic [15:0] ET  = 16'h1919;

  logic        clk125 = 1'b0;
  logic        rst;
  logic        rxctl;
  logic [3:0]  rxd;
  logic [10:0] rxad;
  logic [7:0]  rxdata;
  logic        rxwe, idx, frame_ok, frame_err;
  logic [15:0] seq, good_cnt, err_cnt;

  rgmii_rx #(.MAC_ADDR(MAC), .ETHERTYPE(ET), .PAYLOAD_LEN(PL), .AW(10)) dut (
    .clk125(clk125), .rst(rst), .rxctl(rxctl), .rxd(rxd),
    .rxad(rxad), .rxdata(rxdata), .rxwe(rxwe), .idx(idx), .seq(seq),
    .frame_ok(frame_ok), .frame_err(frame_err),
    .good_cnt(good_cnt), .err_cnt(err_cnt)
  );

  always #4 clk125 = ~clk125;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic        m_idx;
  logic [15:0] m_seq;
  int          m_good, m_err;

  // frame under construction and observations
  logic [31:0] tbl [256];
  logic [7:0]  pay [PL];
  logic [7:0]  fr [$];
  logic [10:0] wa [$];
  logic [7:0]  wd [$];
  int fb, fw, n_ok, n_err, err_pos, both;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp(input int v);
`ifdef RX_STATS_EN
    return (v > 65535) ? 32'hFFFF : 32'(v);
`else
    return 32'(v) & 32'h0;
`endif
  endfunction

  // one byte on the wire: low nibble in the high phase, high nibble in the low phase
  task automatic put(input logic c, input logic [7:0] b);
    rxctl = c;
    rxd   = b[3:0];
    @(negedge clk125);
    #1 rxd = b[7:4];
    @(posedge clk125);
    #1;
    fb++;
    if (rxwe) begin
      wa.push_back(rxad);
      wd.push_back(rxdata);
      if (fw == 0) fw = fb;
    end
    if (frame_ok) n_ok++;
    if (frame_err) begin
      n_err++;
      if (err_pos == 0) err_pos = fb;
    end
    if (frame_ok && frame_err) both++;
  endtask

  task automatic build(input logic [47:0] mac, input logic [15:0] et, input logic [15:0] sq, input int npre);
    logic [7:0]  body [$];
    logic [31:0] c;
    fr.delete();
    for (int i = 0; i < npre; i++) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    for (int i = 0; i < 6; i++) body.push_back(mac[8*i +: 8]);
    for (int i = 0; i < 6; i++) body.push_back(8'($urandom));
    body.push_back(et[15:8]);
    body.push_back(et[7:0]);
    body.push_back(sq[7:0]);
    body.push_back(sq[15:8]);
    for (int i = 0; i < PL; i++) body.push_back(pay[i]);
    c = 32'hFFFF_FFFF;
    foreach (body[i]) c = tbl[8'(c[7:0] ^ body[i])] ^ (c >> 8);
    c = ~c;
    for (int i = 0; i < 4; i++) body.push_back(c[8*i +: 8]);
    foreach (body[i]) fr.push_back(body[i]);
  endtask

  task automatic xfer(input int cut, input int extra, input int gap);
    int n;
    n = (cut < 0) ? fr.size() : cut;
    wa.delete(); wd.delete();
    fb = 0; fw = 0; n_ok = 0; n_err = 0; err_pos = 0; both = 0;
    for (int i = 0; i < n; i++) put(1'b1, fr[i]);
    for (int i = 0; i < extra; i++) put(1'b1, (i % 2 == 0) ? 8'h55 : 8'hD5);
    for (int i = 0; i < gap; i++) put(1'b0, 8'h00);
  endtask

  // flip: payload bit number to corrupt (-1 none); cutpay: payload bytes sent before rxctl falls (-1 none)
  task automatic frame_test(input string tag, input logic [47:0] mac, input logic [15:0] et,
                            input logic [15:0] sq, input int npre, input int flip,
                            input int cutpay, input int extra, input int gap);
    int   hb, pos, nwr, nmis, cut;
    logic hdr_ok, e_ok, bank;
    build(mac, et, sq, npre);
    hb = npre + 17;
    if (flip >= 0) fr[hb + flip / 8] = fr[hb + flip / 8] ^ 8'(1 << (flip % 8));
    hdr_ok = 1'b1;
    pos = 0;
    if (npre > 7) begin
      hdr_ok = 1'b0;
      pos = 8;
    end else begin
      for (int k = 0; k < 6; k++)
        if (hdr_ok && mac[8*k +: 8] != MAC[8*k +: 8]) begin
          hdr_ok = 1'b0;
          pos = npre + 2 + k;
        end
      if (hdr_ok && et[15:8] != ET[15:8]) begin
        hdr_ok = 1'b0;
        pos = npre + 14;
      end else if (hdr_ok && et[7:0] != ET[7:0]) begin
        hdr_ok = 1'b0;
        pos = npre + 15;
      end
    end
    cut = (cutpay < 0) ? -1 : hb + cutpay;
    nwr = !hdr_ok ? 0 : ((cutpay < 0) ? PL : cutpay);
    e_ok = hdr_ok && cutpay < 0 && flip < 0;
    if (hdr_ok) begin
      if (cutpay >= 0)   pos = cut + 1;
      else if (flip >= 0) pos = fr.size();
    end
    bank = ~m_idx;
    xfer(cut, extra, gap);
    chk({tag, " ok pulses"}, n_ok, e_ok ? 1 : 0);
    chk({tag, " err pulses"}, n_err, e_ok ? 0 : 1);
    chk({tag, " err position"}, err_pos, pos);
    chk({tag, " ok&err overlap"}, both, 0);
    chk({tag, " write count"}, wa.size(), nwr);
    if (nwr > 0) chk({tag, " first write position"}, fw, hb + 1);
    nmis = 0;
    for (int i = 0; i < nwr && i < wa.size(); i++)
      if (wa[i] !== {bank, 10'(i)} || wd[i] !== fr[hb + i]) begin
        if (nmis == 0) $display("write %0d: addr=%0h data=%0h want addr=%0h data=%0h",
                                i, wa[i], wd[i], {bank, 10'(i)}, fr[hb + i]);
        nmis++;
      end
    if (nwr > 0) chk({tag, " write contents"}, nmis, 0);
    if (e_ok) begin
      m_idx = ~m_idx;
      m_seq = sq;
      m_good++;
    end else begin
      m_err++;
    end
    chk({tag, " idx"}, idx, m_idx);
    chk({tag, " seq"}, seq, m_seq);
    chk({tag, " good_cnt"}, good_cnt, stat_exp(m_good));
    chk({tag, " err_cnt"}, err_cnt, stat_exp(m_err));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " rxwe"}, rxwe, 0);
    chk({tag, " rxad"}, rxad, 0);
    chk({tag, " rxdata"}, rxdata, 0);
    chk({tag, " idx"}, idx, 0);
    chk({tag, " seq"}, seq, 0);
    chk({tag, " frame_ok"}, frame_ok, 0);
    chk({tag, " frame_err"}, frame_err, 0);
    chk({tag, " good_cnt"}, good_cnt, 0);
    chk({tag, " err_cnt"}, err_cnt, 0);
  endtask

  task automatic rand_pay();
    for (int i = 0; i < PL; i++) pay[i] = 8'($urandom);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] mac;
    logic [31:0] r;
    int          kind;

    for (int n = 0; n < 256; n++) begin
      r = 32'(n);
      for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      tbl[n] = r;
    end
    m_idx = 1'b0; m_seq = '0; m_good = 0; m_err = 0;

    rst = 1'b1; rxctl = 1'b0; rxd = 4'h0;
    repeat (3) @(posedge clk125);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    repeat (2) put(1'b0, 8'h00);

    for (int i = 0; i < PL; i++) pay[i] = 8'(i);
    frame_test("good", MAC, ET, 16'h0102, 7, -1, -1, 0, 2);
    frame_test("payload bit flip", MAC, ET, 16'h0304, 7, 100 * 8 + 3, -1, 0, 2);

    mac = MAC; mac[31:24] = 8'h00;
    rand_pay();
    frame_test("mac byte3", mac, ET, 16'h0506, 7, -1, -1, 0, 2);
    frame_test("ethertype 0800", MAC, 16'h0800, 16'h0708, 7, -1, -1, 0, 2);
    frame_test("truncated pay500", MAC, ET, 16'h090A, 7, -1, 501, 0, 2);
    rand_pay();
    frame_test("good after trunc", MAC, ET, 16'h0B0C, 7, -1, -1, 0, 2);

    for (int f = 0; f < 3; f++) begin
      rand_pay();
      frame_test("back-to-back", MAC, ET, 16'(16'h1000 + f), 7, -1, -1, 0, 1);
    end

    rand_pay();
    frame_test("over-length", MAC, ET, 16'h2222, 7, -1, -1, 5, 2);
    frame_test("preamble 8", MAC, ET, 16'h3333, 8, -1, -1, 0, 2);
    frame_test("preamble 1", MAC, ET, 16'h4444, 1, -1, -1, 0, 2);
    frame_test("truncated hdr", MAC, ET, 16'h4545, 3, -1, 0, 0, 2);

    for (int f = 0; f < 4; f++) begin
      rand_pay();
      kind = $urandom_range(0, 2);
      mac = MAC;
      if (kind == 2) begin
        r = $urandom_range(0, 5);
        mac[8*r +: 8] = ~MAC[8*r +: 8];
      end
      frame_test("random", mac, ET, 16'($urandom), $urandom_range(1, 7),
                 (kind == 1) ? $urandom_range(0, PL * 8 - 1) : -1, -1, 0, 2);
    end

    rand_pay();
    build(MAC, ET, 16'h5555, 7);
    for (int i = 0; i < 7 + 17 + 300; i++) put(1'b1, fr[i]);
    chk("mid-pay writing", rxwe, 1);
    rst = 1'b1;
    #1;
    chk_zero("rst mid-pay");
    rxctl = 1'b0; rxd = 4'h0;
    repeat (3) @(posedge clk125);
    #1;
    rst = 1'b0;
    m_idx = 1'b0; m_seq = '0; m_good = 0; m_err = 0;
    repeat (2) put(1'b0, 8'h00);
    frame_test("good after rst", MAC, ET, 16'h6666, 7, -1, -1, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
